multicycle_controller: RTL and testbench

- Control unit for the multi-cycle ARM-subset datapath.
- Consumes the decoded instruction fields (Cond, Op, Funct, Rd) and the registered Z flag from the datapath.
- Sequences each instruction through FETCH/DECODE/EXECUTE/WRITEBACK states with a Moore FSM.
- Drives every datapath control signal.
- Supports DP register/immediate (ADD, SUB, AND, ORR, MOV, CMP), LDR/STR, B, BL and BX, each with EQ/NE/AL conditions.

---
 rtl/mc_ctrl_pkg.sv | 50 +++++
 rtl/cond_check.sv | 21 ++
 rtl/multicycle_controller.sv | 145 ++++++++++++++
 tb/tb_multicycle_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle ARM-subset control unit: state codes,
// ALU command codes, condition codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BLLINK   = 4'd9;
    localparam state_t S_BRANCH   = 4'd10;
    localparam state_t S_BX       = 4'd11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [5:0] FUNCT_BX = 6'b010010;

    function automatic logic is_bx(input logic [1:0] op, input logic [5:0] funct);
        return (op == OP_DP) && (funct == FUNCT_BX);
    endfunction

endpackage

// File: rtl/cond_check.sv
// Condition evaluation: EQ/NE against the registered Z flag, AL always true,
// every other condition code treated as never-execute.
module cond_check
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic       z_i,
    output logic       cond_ex_o
);

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z_i;
            COND_NE: cond_ex_o = ~z_i;
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing each instruction through fetch/decode/execute/writeback
// and driving every control signal of the multi-cycle datapath.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       Z,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Z_enable,
    output logic       BLenable,
    output logic       BXenable,
    output logic [1:0] RegSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [3:0] ALUControl,
    output logic [3:0] state_dbg
);

    state_t state_q, state_d;
    logic   cond_ex;
    logic   pc_write, mem_write, ir_write, reg_write, z_en;
    logic   instr_bx, imm_bit, sl_bit, cmd_cmp;
    logic [3:0] cmd;

    cond_check u_cond_check (
        .cond_i    (Cond),
        .z_i       (Z),
        .cond_ex_o (cond_ex)
    );

    assign instr_bx = is_bx(Op, Funct);
    assign imm_bit  = Funct[5];
    assign cmd      = Funct[4:1];
    assign sl_bit   = Funct[0];
    assign cmd_cmp  = (cmd == CMD_CMP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        z_en       = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALUOUT;
        ALUControl = CMD_ADD;
        BLenable   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                ALUSrcA   = 1'b1;
                ResultSrc = RES_ALU;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                if (!cond_ex)                          state_d = S_FETCH;
                else if (instr_bx)                     state_d = S_BX;
                else if (Op == OP_DP && !imm_bit)      state_d = S_EXECR;
                else if (Op == OP_DP)                  state_d = S_EXECI;
                else if (Op == OP_MEM)                 state_d = S_MEMADR;
                else if (Op == OP_BR && Funct[4])      state_d = S_BLLINK;
                else if (Op == OP_BR)                  state_d = S_BRANCH;
                else                                   state_d = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = sl_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECR) ? SRCB_REG : SRCB_IMM;
                ALUControl = cmd_cmp ? CMD_SUB : cmd;
                z_en       = sl_bit | cmd_cmp;
                state_d    = cmd_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                // Writes to R15 redirect the PC instead of the register file.
                if (Rd == 4'd15) pc_write  = 1'b1;
                else             reg_write = 1'b1;
            end
            S_BLLINK: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_ZERO;
                ResultSrc = RES_ALU;
                reg_write = 1'b1;
                BLenable  = 1'b1;
                state_d   = S_BRANCH;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                pc_write  = 1'b1;
            end
            S_BX: begin
                ALUSrcB   = SRCB_ZERO;
                ResultSrc = RES_ALU;
                pc_write  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign PCWrite   = pc_write  & ~reset;
    assign MemWrite  = mem_write & ~reset;
    assign IRWrite   = ir_write  & ~reset;
    assign RegWrite  = reg_write & ~reset;
    assign Z_enable  = z_en      & ~reset;
    assign BXenable  = instr_bx && (state_q == S_DECODE || state_q == S_BX);
    assign RegSrc    = {(Op == OP_MEM) && !sl_bit, Op == OP_BR};
    assign ImmSrc    = Op;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction cycle-by-cycle
// expectations are queued by the stimulus and popped by a negedge monitor.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       Z;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Z_enable, BLenable, BXenable;
    logic [1:0] RegSrc, ImmSrc, ALUSrcB, ResultSrc;
    logic [3:0] ALUControl, state_dbg;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .Z(Z),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Z_enable(Z_enable), .BLenable(BLenable),
        .BXenable(BXenable), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, memw, irw, regw, zen, adr, asa;
        logic [1:0] asb, rs;
        logic [3:0] alu;
        logic       bl, bx;
        logic [1:0] regsrc, imm;
    } rec_t;

    rec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 0;

    // Expected outputs for one cycle in a named state of the given instruction.
    function automatic rec_t exp_rec(input int st, input logic [1:0] op,
                                     input logic [5:0] f, input logic [3:0] rd);
        rec_t r;
        r        = '0;
        r.st     = st[3:0];
        r.alu    = 4'b0100;
        r.asb    = 2'b10;
        r.regsrc = {(op == 2'b01) && !f[0], op == 2'b10};
        r.imm    = op;
        r.bx     = (st == 1 || st == 11) && op == 2'b00 && f == 6'b010010;
        case (st)
            0:  begin r.irw = 1; r.pcw = 1; r.asa = 1; r.rs = 2'b10; end
            1:  r.asa = 1;
            2:  r.asb = 2'b01;
            3:  r.adr = 1;
            4:  begin r.rs = 2'b01; r.regw = 1; end
            5:  begin r.adr = 1; r.memw = 1; end
            6, 7: begin
                r.asb = (st == 6) ? 2'b00 : 2'b01;
                r.alu = (f[4:1] == 4'b1010) ? 4'b0010 : f[4:1];
                r.zen = f[0] || (f[4:1] == 4'b1010);
            end
            8:  if (rd == 4'd15) r.pcw = 1; else r.regw = 1;
            9:  begin r.asa = 1; r.asb = 2'b11; r.rs = 2'b10; r.regw = 1; r.bl = 1; end
            10: begin r.asa = 1; r.asb = 2'b01; r.rs = 2'b10; r.pcw = 1; end
            11: begin r.asb = 2'b11; r.rs = 2'b10; r.pcw = 1; end
            default: ;
        endcase
        return r;
    endfunction

    // Which states an instruction visits, from its class and condition outcome.
    task automatic state_path(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                              input logic z, output int path[$]);
        bit ex;
        path = {0, 1};
        ex = (c == 4'b0000) ? z : (c == 4'b0001) ? !z : (c == 4'b1110);
        if (!ex) return;
        if (op == 2'b00 && f == 6'b010010) path.push_back(11);
        else if (op == 2'b00) begin
            path.push_back(f[5] ? 7 : 6);
            if (f[4:1] != 4'b1010) path.push_back(8);
        end
        else if (op == 2'b01) begin
            path.push_back(2);
            if (f[0]) begin path.push_back(3); path.push_back(4); end
            else path.push_back(5);
        end
        else if (op == 2'b10) begin
            if (f[4]) path.push_back(9);
            path.push_back(10);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Called at the start of a FETCH cycle; returns at the start of the next FETCH.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input logic z);
        int path[$];
        Cond = c; Op = op; Funct = f; Rd = rd; Z = z;
        state_path(c, op, f, z, path);
        foreach (path[i]) exp_q.push_back(exp_rec(path[i], op, f, rd));
        repeat (path.size()) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            rec_t e, a;
            a = '{state_dbg, PCWrite, MemWrite, IRWrite, RegWrite, Z_enable, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ALUControl, BLenable, BXenable, RegSrc, ImmSrc};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got state %0d with no expectation at %0t", state_dbg, $time);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_st%0d: got %h expected %h (Op=%b Funct=%b Cond=%b Z=%b) at %0t",
                             e.st, a, e, Op, Funct, Cond, Z, $time);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] c, rd;
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] cmds[6];
        cmds = '{4'b0000, 4'b0010, 4'b0100, 4'b1010, 4'b1100, 4'b1101};
        reset = 1'b1; Cond = 4'b1110; Op = 2'b00; Funct = 6'b0; Rd = 4'd0; Z = 1'b0;
        #2;
        check("reset_state", 32'(state_dbg), 32'd0);
        check("reset_pcwrite", 32'(PCWrite), 32'd0);
        check("reset_irwrite", 32'(IRWrite), 32'd0);
        check("reset_alusrcb", 32'(ALUSrcB), 32'd2);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1;

        run_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 1'b0);   // ADD R1,R2,R3
        run_instr(4'b1110, 2'b00, 6'b110101, 4'd0, 1'b0);   // CMP imm
        run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 1'b1);   // BEQ taken
        run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 1'b0);   // BEQ not taken
        run_instr(4'b1110, 2'b01, 6'b011001, 4'd3, 1'b0);   // LDR
        run_instr(4'b1110, 2'b01, 6'b011000, 4'd3, 1'b0);   // STR
        run_instr(4'b1110, 2'b10, 6'b010000, 4'd0, 1'b0);   // BL
        run_instr(4'b1110, 2'b00, 6'b010010, 4'd0, 1'b0);   // BX
        run_instr(4'b1110, 2'b00, 6'b011010, 4'd15, 1'b0);  // MOV PC
        run_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 1'b0);   // Op=11 NOP
        run_instr(4'b0001, 2'b00, 6'b001000, 4'd2, 1'b0);   // ADDNE taken
        run_instr(4'b0101, 2'b01, 6'b011001, 4'd2, 1'b1);   // unsupported cond

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: c = 4'b0000;
                1: c = 4'b0001;
                2: c = 4'($urandom);
                default: c = 4'b1110;
            endcase
            op = 2'($urandom);
            if (op == 2'b00) begin
                if ($urandom_range(0, 7) == 0) f = 6'b010010;
                else f = {1'($urandom), cmds[$urandom_range(0, 5)], 1'($urandom)};
            end else f = 6'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            run_instr(c, op, f, rd, 1'($urandom));
        end

        // Reset in the middle of a store must abort it immediately.
        mon_en = 0;
        Cond = 4'b1110; Op = 2'b01; Funct = 6'b011000; Rd = 4'd0; Z = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_state", 32'(state_dbg), 32'd5);
        check("pre_reset_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_state", 32'(state_dbg), 32'd0);
        check("midreset_memwrite", 32'(MemWrite), 32'd0);
        check("midreset_pcwrite", 32'(PCWrite), 32'd0);
        check("midreset_irwrite", 32'(IRWrite), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("post_reset_irwrite", 32'(IRWrite), 32'd1);
        check("post_reset_pcwrite", 32'(PCWrite), 32'd1);
        mon_en = 1;
        run_instr(4'b1110, 2'b01, 6'b011001, 4'd4, 1'b0);
        mon_en = 0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
